// File: rtl/mem_stage_dcache.sv
// ---------------------------------------------------------------------------
// mem_stage_dcache
//
// Memory-access stage of the pipelined MIPS datapath. It produces the inputs
// of the MEM/WB register. The stage contains a direct-mapped data cache with
// one word per line. Stores are write-through, and a store miss allocates no
// line. A req/ack port connects the cache to backing memory. While a read
// miss or a write-through is outstanding, the stage stalls the pipeline.
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   MemRead, MemWrite         load / store request from EX/MEM
//   address, writeData        byte address (low two bits ignored), store data
//   ALUResult, writeReg,
//   RegWrite, MemtoReg        EX/MEM values passed through to MEM/WB
//   hit, readData             lookup result and load data to MEM/WB
//   ALUResultOut, writeRegOut,
//   RegWriteOut, MemtoRegOut  pass-through outputs (RegWriteOut is gated by stall)
//   stall                     freezes PC, IF/ID, ID/EX and EX/MEM
//   mem_req, mem_we,
//   mem_addr, mem_wdata       backing-memory request
//   mem_rdata, mem_ack        backing-memory response (ack is a one-cycle pulse)
//   hit_count, miss_count     saturating performance counters
// ---------------------------------------------------------------------------
module mem_stage_dcache #(
    parameter int IDX_BITS = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [31:0]         address,
    input  logic [31:0]         writeData,
    input  logic [31:0]         ALUResult,
    input  logic [4:0]          writeReg,
    input  logic                RegWrite,
    input  logic                MemtoReg,
    output logic                hit,
    output logic [31:0]         readData,
    output logic [31:0]         ALUResultOut,
    output logic [4:0]          writeRegOut,
    output logic                RegWriteOut,
    output logic                MemtoRegOut,
    output logic                stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    input  logic                mem_ack,
    output logic [CNT_BITS-1:0] hit_count,
    output logic [CNT_BITS-1:0] miss_count
);

    localparam int LINES    = 1 << IDX_BITS;
    localparam int TAG_BITS = 32 - IDX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU,
        REFILL
    } state_t;

    state_t              state_q, state_d;
    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];
    logic [CNT_BITS-1:0] hitCount_q, missCount_q;

    logic [IDX_BITS-1:0] index;
    logic [TAG_BITS-1:0] tag;
    logic                lookupHit;
    logic                lineWrite;
    logic                lineFill;
    logic [31:0]         lineData;
    logic                hitInc;
    logic                missInc;
    logic                unusedAddrBits;

    // Every access is a word access, so the byte offset is deliberately dropped.
    assign unusedAddrBits = ^address[1:0];

    assign index     = address[IDX_BITS+1:2];
    assign tag       = address[31:IDX_BITS+2];
    assign lookupHit = valid_q[index] && (tag_q[index] == tag);

    // The stage forwards the EX/MEM values unchanged. The one exception is
    // RegWrite, which is held low while stalled. Otherwise the same
    // instruction would be written back more than once.
    assign ALUResultOut = ALUResult;
    assign writeRegOut  = writeReg;
    assign MemtoRegOut  = MemtoReg;
    assign RegWriteOut  = RegWrite & ~stall;
    assign mem_addr     = {address[31:2], 2'b00};
    assign hit_count    = hitCount_q;
    assign miss_count   = missCount_q;

    // Next-state and output decode. In IDLE the lookup result drives the
    // outputs directly, so a read hit costs no extra cycle. A store has
    // priority over a load. A store hit updates the line on the same edge it
    // is seen, and a store miss leaves the cache untouched. A store retires
    // in its ack cycle, so stall drops in that cycle. A refilled load retires
    // one cycle after its ack, in REFILL, and reads the newly written line.
    always_comb begin
        state_d   = state_q;
        hit       = 1'b0;
        readData  = 32'h0;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
        lineWrite = 1'b0;
        lineFill  = 1'b0;
        lineData  = writeData;
        hitInc    = 1'b0;
        missInc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    hit     = lookupHit;
                    stall   = 1'b1;
                    state_d = WR_THRU;
                    if (lookupHit) begin
                        lineWrite = 1'b1;
                        hitInc    = 1'b1;
                    end
                end else if (MemRead) begin
                    if (lookupHit) begin
                        hit      = 1'b1;
                        readData = data_q[index];
                        hitInc   = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        missInc = 1'b1;
                        state_d = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_ack) begin
                    lineWrite = 1'b1;
                    lineFill  = 1'b1;
                    lineData  = mem_rdata;
                    state_d   = REFILL;
                end
            end
            REFILL: begin
                hit      = 1'b1;
                readData = data_q[index];
                state_d  = IDLE;
            end
            WR_THRU: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = writeData;
                stall     = 1'b1;
                if (mem_ack) begin
                    stall   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, valid bits and counters. Reset returns the FSM to IDLE, so any
    // outstanding request is dropped and a later stray ack has no effect.
    // Both counters stop at all-ones and never wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            hitCount_q  <= '0;
            missCount_q <= '0;
        end else begin
            state_q <= state_d;
            if (lineFill) begin
                valid_q[index] <= 1'b1;
            end
            if (hitInc && (hitCount_q != {CNT_BITS{1'b1}})) begin
                hitCount_q <= hitCount_q + CNT_BITS'(1);
            end
            if (missInc && (missCount_q != {CNT_BITS{1'b1}})) begin
                missCount_q <= missCount_q + CNT_BITS'(1);
            end
        end
    end

    // The tag and data arrays need no reset. The cleared valid bits already
    // mark their contents as meaningless.
    always_ff @(posedge clock) begin
        if (lineWrite) begin
            data_q[index] <= lineData;
        end
        if (lineFill) begin
            tag_q[index] <= tag;
        end
    end

endmodule

// File: tb/tb_mem_stage_dcache.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_dcache
//
// Testbench for mem_stage_dcache. Each load that should retire pushes its
// expected data onto a queue, and each backing-memory transaction that should
// occur pushes its expected request onto a second queue. A monitor pops these
// entries when the DUT retires a load or completes a memory handshake. The
// scenario tasks check stall lengths, pass-through values and counter values
// inline. The counters are 4 bits wide here, which keeps saturation reachable.
// ---------------------------------------------------------------------------
module tb_mem_stage_dcache;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memTxn_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] address, writeData, ALUResult;
    logic [4:0]  writeReg;
    logic        RegWrite, MemtoReg;
    logic        hit;
    logic [31:0] readData, ALUResultOut;
    logic [4:0]  writeRegOut;
    logic        RegWriteOut, MemtoRegOut, stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [3:0]  hit_count, miss_count;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] rdQ[$];
    memTxn_t     memQ[$];

    mem_stage_dcache #(.IDX_BITS(4), .CNT_BITS(4)) dut (
        .clock(clock), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .address(address), .writeData(writeData),
        .ALUResult(ALUResult), .writeReg(writeReg),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .hit(hit), .readData(readData),
        .ALUResultOut(ALUResultOut), .writeRegOut(writeRegOut),
        .RegWriteOut(RegWriteOut), .MemtoRegOut(MemtoRegOut),
        .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    // The scoreboard monitor samples on the falling edge. A load retires when
    // MemRead is present and stall is low. A memory transaction completes on
    // a cycle where both req and ack are high.
    always @(negedge clock) begin
        if (!reset && MemRead && !MemWrite && !stall) begin
            assertCount++;
            if (rdQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL load_retire: unexpected load retire, readData %h", readData);
            end else begin
                logic [31:0] expData;
                expData = rdQ.pop_front();
                if (readData !== expData || hit !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL load_data: got %h hit %b, expected %h hit 1",
                             readData, hit, expData);
                end
            end
        end
        if (!reset && mem_req === 1'b1 && mem_ack === 1'b1) begin
            assertCount++;
            if (memQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL mem_txn: unexpected transaction we %b addr %h", mem_we, mem_addr);
            end else begin
                memTxn_t expTxn;
                expTxn = memQ.pop_front();
                if (mem_we !== expTxn.we || mem_addr !== expTxn.addr ||
                    (expTxn.we && mem_wdata !== expTxn.wdata)) begin
                    failCount++;
                    $display("[TB] FAIL mem_txn: got we %b addr %h wdata %h, expected we %b addr %h wdata %h",
                             mem_we, mem_addr, mem_wdata, expTxn.we, expTxn.addr, expTxn.wdata);
                end
            end
        end
    end

    // Drives one access. The task is entered just after a rising edge and
    // returns just after the rising edge that follows the retire cycle. The
    // backing-memory model raises ack on the lat-th cycle that mem_req is high.
    task automatic runAccess(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                             input int lat, input logic [31:0] rd,
                             output int stallCyc, output int reqCyc, output int rwDuringStall,
                             output logic firstHit, output logic finalRw, output logic [4:0] finalWr,
                             output logic [31:0] finalAlu);
        int  reqSeen = 0;
        int  cyc     = 0;
        bit  done    = 0;
        stallCyc = 0; reqCyc = 0; rwDuringStall = 0;
        firstHit = 1'b0; finalRw = 1'b0; finalWr = 5'd0; finalAlu = 32'h0;
        MemRead   = !wr;
        MemWrite  = wr;
        address   = addr;
        writeData = wd;
        ALUResult = addr;
        while (!done && cyc < 50) begin
            if (mem_req === 1'b1) begin
                reqSeen++;
                if (reqSeen == lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
            end
            @(negedge clock);
            if (cyc == 0) firstHit = hit;
            if (stall === 1'b1) begin
                stallCyc++;
                if (RegWriteOut !== 1'b0) rwDuringStall++;
            end
            if (mem_req === 1'b1) reqCyc++;
            if (stall === 1'b0) begin
                done     = 1;
                finalRw  = RegWriteOut;
                finalWr  = writeRegOut;
                finalAlu = ALUResultOut;
            end
            @(posedge clock);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            cyc++;
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if (!done) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL access_timeout: addr %h still stalled after %0d cycles, required retire", addr, cyc);
        end
    endtask

    // Drives a load. It predicts either a hit, or a miss with a memory read.
    task automatic applyRead(input logic [31:0] addr, input bit expHit, input int lat,
                             input logic [31:0] data, output int stallCyc, output int reqCyc);
        int rw; logic fh, frw; logic [4:0] fwr; logic [31:0] fal;
        rdQ.push_back(data);
        if (!expHit) memQ.push_back('{we: 1'b0, addr: {addr[31:2], 2'b00}, wdata: 32'h0});
        runAccess(1'b0, addr, 32'h0, lat, data, stallCyc, reqCyc, rw, fh, frw, fwr, fal);
    endtask

    task automatic applyWrite(input logic [31:0] addr, input logic [31:0] data, input int lat,
                              output int stallCyc, output int reqCyc, output logic firstHit);
        int rw; logic frw; logic [4:0] fwr; logic [31:0] fal;
        memQ.push_back('{we: 1'b1, addr: {addr[31:2], 2'b00}, wdata: data});
        runAccess(1'b1, addr, data, lat, 32'h0, stallCyc, reqCyc, rw, firstHit, frw, fwr, fal);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        assertCount++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || hit !== 1'b0 || readData !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: stall %b req %b we %b hit %b rd %h, required all 0",
                     stall, mem_req, mem_we, hit, readData);
        end
        assertCount++;
        if (hit_count !== 4'd0 || miss_count !== 4'd0) begin
            failCount++;
            $display("[TB] FAIL reset_counters: hit %0d miss %0d, required 0 0", hit_count, miss_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_read_miss;
        int s, r;
        applyRead(32'h40, 1'b0, 3, 32'hDEADBEEF, s, r);
        assertCount++;
        if (s != 4 || r != 3) begin
            failCount++;
            $display("[TB] FAIL miss_latency: stall %0d req %0d, required 4 3", s, r);
        end
        assertCount++;
        if (miss_count !== 4'd1 || hit_count !== 4'd0) begin
            failCount++;
            $display("[TB] FAIL miss_count1: miss %0d hit %0d, required 1 0", miss_count, hit_count);
        end
    endtask

    task automatic test_read_hit;
        int s, r;
        applyRead(32'h40, 1'b1, 1, 32'hDEADBEEF, s, r);
        assertCount++;
        if (s != 0 || r != 0 || hit_count !== 4'd1) begin
            failCount++;
            $display("[TB] FAIL read_hit: stall %0d req %0d hit_count %0d, required 0 0 1", s, r, hit_count);
        end
    endtask

    task automatic test_conflict;
        int s, r;
        applyRead(32'h80, 1'b0, 2, 32'hCAFEF00D, s, r);
        assertCount++;
        if (s != 3 || miss_count !== 4'd2) begin
            failCount++;
            $display("[TB] FAIL conflict_miss: stall %0d miss %0d, required 3 2", s, miss_count);
        end
        applyRead(32'h40, 1'b0, 1, 32'hDEADBEEF, s, r);
        assertCount++;
        if (s != 2 || miss_count !== 4'd3) begin
            failCount++;
            $display("[TB] FAIL evicted_miss: stall %0d miss %0d, required 2 3", s, miss_count);
        end
    endtask

    task automatic test_write_through;
        int s, r; logic fh;
        applyRead(32'h80, 1'b0, 1, 32'hCAFEF00D, s, r);
        applyWrite(32'h80, 32'h12345678, 2, s, r, fh);
        assertCount++;
        if (s != 2 || r != 2 || fh !== 1'b1 || hit_count !== 4'd2) begin
            failCount++;
            $display("[TB] FAIL write_hit: stall %0d req %0d hit %b hit_count %0d, required 2 2 1 2",
                     s, r, fh, hit_count);
        end
        applyRead(32'h80, 1'b1, 1, 32'h12345678, s, r);
        assertCount++;
        if (s != 0 || hit_count !== 4'd3) begin
            failCount++;
            $display("[TB] FAIL write_readback: stall %0d hit_count %0d, required 0 3", s, hit_count);
        end
        applyWrite(32'hC4, 32'h00000055, 1, s, r, fh);
        assertCount++;
        if (s != 1 || fh !== 1'b0 || hit_count !== 4'd3 || miss_count !== 4'd4) begin
            failCount++;
            $display("[TB] FAIL write_miss: stall %0d hit %b counts %0d/%0d, required 1 0 3/4",
                     s, fh, hit_count, miss_count);
        end
        applyRead(32'hC4, 1'b0, 1, 32'h00000077, s, r);
        assertCount++;
        if (s != 2 || miss_count !== 4'd5) begin
            failCount++;
            $display("[TB] FAIL no_allocate: stall %0d miss %0d, required 2 5", s, miss_count);
        end
    endtask

    task automatic test_reset_abort;
        int s, r;
        MemRead = 1'b1; address = 32'h100; ALUResult = 32'h100;
        @(posedge clock); #1;
        assertCount++;
        if (mem_req !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL abort_req_up: mem_req %b, required 1", mem_req);
        end
        reset = 1'b1; MemRead = 1'b0;
        @(posedge clock); #1;
        assertCount++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || miss_count !== 4'd0 || hit_count !== 4'd0) begin
            failCount++;
            $display("[TB] FAIL abort_drop: req %b stall %b counts %0d/%0d, required 0 0 0/0",
                     mem_req, stall, hit_count, miss_count);
        end
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h00000BAD;
        @(posedge clock); #1;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        assertCount++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL stray_ack: req %b stall %b, required 0 0", mem_req, stall);
        end
        applyRead(32'h100, 1'b0, 1, 32'h00001111, s, r);
        assertCount++;
        if (s != 2 || miss_count !== 4'd1) begin
            failCount++;
            $display("[TB] FAIL abort_remiss: stall %0d miss %0d, required 2 1", s, miss_count);
        end
        applyRead(32'hC4, 1'b0, 1, 32'h00002222, s, r);
        assertCount++;
        if (s != 2 || miss_count !== 4'd2) begin
            failCount++;
            $display("[TB] FAIL valid_cleared: stall %0d miss %0d, required 2 2", s, miss_count);
        end
    endtask

    task automatic test_regwrite_stall;
        int s, r, rw; logic fh, frw; logic [4:0] fwr; logic [31:0] fal;
        RegWrite = 1'b1; writeReg = 5'd5; MemtoReg = 1'b1;
        rdQ.push_back(32'hA5A5A5A5);
        memQ.push_back('{we: 1'b0, addr: 32'h140, wdata: 32'h0});
        runAccess(1'b0, 32'h140, 32'h0, 1, 32'hA5A5A5A5, s, r, rw, fh, frw, fwr, fal);
        assertCount++;
        if (rw != 0 || s != 2) begin
            failCount++;
            $display("[TB] FAIL regwrite_gate: RegWriteOut high in %0d stall cycles, stall %0d, required 0 2", rw, s);
        end
        assertCount++;
        if (frw !== 1'b1 || fwr !== 5'd5 || fal !== 32'h140 || MemtoRegOut !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL refill_passthru: rw %b wr %0d alu %h mtr %b, required 1 5 00000140 1",
                     frw, fwr, fal, MemtoRegOut);
        end
        RegWrite = 1'b0; writeReg = 5'd0; MemtoReg = 1'b0;
    endtask

    task automatic test_back_to_back;
        int s, r; logic fh;
        applyRead(32'h140, 1'b1, 1, 32'hA5A5A5A5, s, r);
        applyWrite(32'h140, 32'h0BADF00D, 1, s, r, fh);
        applyRead(32'h140, 1'b1, 1, 32'h0BADF00D, s, r);
        assertCount++;
        if (s != 0 || hit_count !== 4'd3) begin
            failCount++;
            $display("[TB] FAIL back_to_back: stall %0d hit_count %0d, required 0 3", s, hit_count);
        end
    endtask

    task automatic test_saturation;
        int s, r;
        for (int i = 0; i < 20; i++) applyRead(32'h140, 1'b1, 1, 32'h0BADF00D, s, r);
        assertCount++;
        if (hit_count !== 4'hF) begin
            failCount++;
            $display("[TB] FAIL hit_saturate: hit_count %0d, required 15", hit_count);
        end
        for (int i = 0; i < 14; i++) begin
            applyRead((i % 2 == 0) ? 32'h200 : 32'h240, 1'b0, 1, 32'h1000 + i, s, r);
        end
        assertCount++;
        if (miss_count !== 4'hF || hit_count !== 4'hF) begin
            failCount++;
            $display("[TB] FAIL miss_saturate: miss %0d hit %0d, required 15 15", miss_count, hit_count);
        end
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        address = 32'h0; writeData = 32'h0; ALUResult = 32'h0;
        writeReg = 5'd0; RegWrite = 1'b0; MemtoReg = 1'b0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        test_reset;
        test_read_miss;
        test_read_hit;
        test_conflict;
        test_write_through;
        test_reset_abort;
        test_regwrite_stall;
        test_back_to_back;
        test_saturation;
        repeat (2) @(posedge clock);
        assertCount++;
        if (rdQ.size() != 0 || memQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_drain: %0d loads and %0d memory transactions left, required 0 0",
                     rdQ.size(), memQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_stage_dcache.md
Name: mem_stage_dcache

Overview:
Memory-access stage of the pipelined MIPS datapath. It sits directly upstream of the MEM/WB pipeline register and produces that register's inputs: hit, readData, ALUResult, writeReg, RegWrite and MemtoReg. The block is a direct-mapped, one-word-per-line, write-through, no-write-allocate data cache with a req/ack backing-memory port. While a miss or write-through is outstanding it stalls the pipeline.

Parameters:
IDX_BITS, 4, index width; the cache holds 2**IDX_BITS lines.
CNT_BITS, 16, width of the saturating hit and miss performance counters.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
MemRead  in  1  load request from EX/MEM
MemWrite  in  1  store request from EX/MEM
address  in  32  byte address (equals ALUResult for loads and stores)
writeData  in  32  store data
ALUResult  in  32  ALU result, passed through
writeReg  in  5  destination register, passed through
RegWrite  in  1  register-write control, passed through
MemtoReg  in  1  writeback-select control, passed through
hit  out  1  lookup hit indication to MEM/WB
readData  out  32  load data to MEM/WB
ALUResultOut  out  32  to MEM/WB
writeRegOut  out  5  to MEM/WB
RegWriteOut  out  1  to MEM/WB; forced to 0 while stall is 1
MemtoRegOut  out  1  to MEM/WB
stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
mem_req  out  1  backing-memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  32  word-aligned address, {address[31:2],2'b00}
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid while mem_ack is 1
mem_ack  in  1  one-cycle completion pulse
hit_count  out  CNT_BITS  saturating count of accesses that hit
miss_count  out  CNT_BITS  saturating count of read misses

Behaviour:
Address decode:
- index = address[IDX_BITS+1:2]; tag = address[31:IDX_BITS+2].
- address[1:0] is ignored; all accesses are word accesses.
- Storage per line: valid bit, tag, 32-bit data.
- lookup_hit = valid[index] & (tag_array[index] == tag).

Reset:
- All valid bits cleared; FSM goes to IDLE.
- mem_req = 0, mem_we = 0, stall = 0, hit = 0, readData = 0, both counters = 0.
- Reset mid-transaction aborts it. mem_req drops on the next edge, and any later mem_ack is ignored.

FSM states: IDLE, RD_MISS, WR_THRU, REFILL.

IDLE (outputs combinational from the inputs):
- Neither MemRead nor MemWrite: hit = 0, stall = 0, readData = 0.
- MemRead with lookup_hit: hit = 1, readData = line data, stall = 0, hit_count += 1. Zero added latency.
- MemRead without a hit: hit = 0, stall = 1, miss_count += 1, next state RD_MISS.
- MemWrite (takes priority if MemRead is also 1): hit = lookup_hit, stall = 1. If hit, update line data on this edge and hit_count += 1. Next state WR_THRU. A write miss allocates nothing.

RD_MISS:
- mem_req = 1, mem_we = 0, stall = 1.
- On mem_ack: write mem_rdata into the line, set valid, set tag, go to REFILL.
- mem_req stays high until the cycle mem_ack arrives. An ack in the first RD_MISS cycle is legal.

REFILL:
- stall = 0 and hit = 1; readData comes from the refilled line. Return to IDLE.
- Load-miss latency = (memory latency + 2) cycles from the first stalled cycle.

WR_THRU:
- mem_req = 1, mem_we = 1, mem_wdata = writeData, stall = 1.
- On mem_ack: go to IDLE with stall = 0 in that ack cycle, so the store retires.

Stall and pass-through rules:
- While stall = 1, all inputs are held stable by upstream.
- ALUResultOut, writeRegOut and MemtoRegOut are combinational pass-through.
- RegWriteOut = RegWrite & ~stall.

Counters:
- Saturate at all-ones and never wrap.
- A refill completion does not increment hit_count.

Test Plan:
1. Reset, then MemRead addr 0x40 with mem_ack after 3 cycles and mem_rdata = 0xDEADBEEF -> stall high for 4 cycles, one mem_req read at 0x40, REFILL cycle shows hit = 1 and readData = 0xDEADBEEF, miss_count = 1.
2. Repeat MemRead 0x40 -> hit = 1 the same cycle, stall = 0, no mem_req, hit_count = 1.
3. MemRead 0x80 (same index as 0x40 when IDX_BITS = 4, different tag) -> miss, line replaced. MemRead 0x40 afterwards misses again, miss_count = 3.
4. MemWrite 0x80 data 0x12345678 (hit) -> mem_req with mem_we = 1 and mem_wdata = 0x12345678, stall until ack. A following MemRead 0x80 hits with 0x12345678. MemWrite to an uncached 0xC4 leaves 0xC4 invalid.
5. Assert reset during RD_MISS before ack, then pulse mem_ack -> mem_req = 0 on the next edge, ack ignored, a read of the same address misses again.
6. MemRead miss with RegWrite = 1, writeReg = 5 -> RegWriteOut = 0 throughout the stall and 1 with writeRegOut = 5 in the REFILL cycle. Zero-latency ack (ack in first RD_MISS cycle) -> correct data.
